ordenador_comparador: RTL



---
 rtl/ordenador_comparador.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ordenador_comparador.sv
// Four-element sorter: a fixed 5-step sorting network driven through one shared
// 4-bit magnitude comparator, one compare-and-swap per clock.

module comparador_4bits (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic       o_a_maior_b,
  output logic       o_a_menor_b,
  output logic       o_a_igual_b
);
  assign o_a_maior_b = (i_a >  i_b);
  assign o_a_menor_b = (i_a <  i_b);
  assign o_a_igual_b = (i_a == i_b);
endmodule

module ordenador_comparador #(
  parameter int WIDTH = 4,
  parameter int DESC  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [4*WIDTH-1:0] dado_in,
  output logic               ocupado,
  output logic               pronto,
  output logic [4*WIDTH-1:0] dado_out,
  output logic [2:0]         trocas
);

  typedef enum logic [1:0] {OCIOSO, COMPARA, FIM} estado_t;

  estado_t          r_estado, w_prox;
  logic [WIDTH-1:0] r_elem [4];
  logic [WIDTH-1:0] w_novo [4];
  logic [2:0]       r_passo;
  logic [2:0]       r_cont;
  logic [2:0]       w_cont_novo;
  logic [4*WIDTH-1:0] r_dado_out;
  logic [2:0]       r_trocas;
  logic [1:0]       w_i, w_j;
  logic [WIDTH-1:0] w_a, w_b;
  logic             w_maior, w_menor, w_igual, w_troca;

  // Sorting network pair schedule: (0,1) (2,3) (0,2) (1,3) (1,2).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_i = 2'd1;
    w_j = 2'd2;
    case (r_passo)
      3'd0: begin w_i = 2'd0; w_j = 2'd1; end
      3'd1: begin w_i = 2'd2; w_j = 2'd3; end
      3'd2: begin w_i = 2'd0; w_j = 2'd2; end
      3'd3: begin w_i = 2'd1; w_j = 2'd3; end
      default: ;
    endcase
  end

  assign w_a = r_elem[w_i];
  assign w_b = r_elem[w_j];

  comparador_4bits u_comparador (
    .i_a         (w_a),
    .i_b         (w_b),
    .o_a_maior_b (w_maior),
    .o_a_menor_b (w_menor),
    .o_a_igual_b (w_igual)
  );

  // Equal operands never swap, whatever the sort direction.
  assign w_troca     = !w_igual && ((DESC != 0) ? w_menor : w_maior);
  assign w_cont_novo = r_cont + {2'b00, w_troca};

  always_comb begin
    w_novo = r_elem;
    if (w_troca) begin
      w_novo[w_i] = w_b;
      w_novo[w_j] = w_a;
    end
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO:  if (start) w_prox = COMPARA;
      COMPARA: if (r_passo == 3'd4) w_prox = FIM;
      FIM:     w_prox = OCIOSO;
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) r_estado <= OCIOSO;
    else        r_estado <= w_prox;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the element file is only four words, so it is cleared on reset like any other register.
      for (int k = 0; k < 4; k++) r_elem[k] <= '0;
      r_passo    <= '0;
      r_cont     <= '0;
      r_dado_out <= '0;
      r_trocas   <= '0;
    end else begin
      case (r_estado)
        OCIOSO: if (start) begin
          for (int k = 0; k < 4; k++) r_elem[k] <= dado_in[k*WIDTH +: WIDTH];
          r_passo <= '0;
          r_cont  <= '0;
        end
        COMPARA: begin
          for (int k = 0; k < 4; k++) r_elem[k] <= w_novo[k];
          r_cont  <= w_cont_novo;
          r_passo <= r_passo + 3'd1;
          // Result registers load on the edge into FIM and hold until the next sort ends.
          if (r_passo == 3'd4) begin
            r_dado_out <= {w_novo[3], w_novo[2], w_novo[1], w_novo[0]};
            r_trocas   <= w_cont_novo;
          end
        end
        default: ;
      endcase
    end
  end

  assign ocupado  = (r_estado != OCIOSO);
  assign pronto   = (r_estado == FIM);
  assign dado_out = r_dado_out;
  assign trocas   = r_trocas;

endmodule
